hazard_controller: RTL and testbench

- Pipeline scheduler for the 5-stage MIPS core.
- Decides stall and flush control for the IF/ID and ID/EX pipeline registers, drives FlushE into the ID/EX register, and selects operand forwarding for the ID and EX stages.
- Sequences a multi-cycle multiply/divide unit with a busy FSM and countdown, so dependent instructions are held in ID until HI/LO is valid.

---
 rtl/hazard_controller.sv | 116 +++++++++++
 tb/tb_hazard_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Stall/flush/forward control for the 5-stage pipeline plus mult/div busy sequencing; stalls are zero-latency combinational.
// HI/LO goes valid MD_LATENCY cycles after MdStartE. Optional perf counters are enabled by HAZ_PERF_CNT_EN.
`timescale 1ns/1ps
module hazard_controller #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemToRegE,
  input  logic       MemToRegM,
  input  logic       BranchD,
  input  logic       PCSrcD,
  input  logic       JumpD,
  input  logic       MdStartE,
  input  logic       MdUseD,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MdBusy,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdState_t;

  mdState_t         mdState;
  logic [CNT_W-1:0] mdCnt;

  logic writeM, writeW, writeE, loadM;
  logic lwStall, brStall, mdStall, stall;

  assign writeE = RegWriteE && (WriteRegE != 5'd0);
  assign writeM = RegWriteM && (WriteRegM != 5'd0);
  assign writeW = RegWriteW && (WriteRegW != 5'd0);
  assign loadM  = MemToRegM && (WriteRegM != 5'd0);

  // MEM result is newer than WB, so it wins when both match.
  always_comb begin
    ForwardAE = 2'b00;
    if (writeM && (WriteRegM == rsE))      ForwardAE = 2'b10;
    else if (writeW && (WriteRegW == rsE)) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (writeM && (WriteRegM == rtE))      ForwardBE = 2'b10;
    else if (writeW && (WriteRegW == rtE)) ForwardBE = 2'b01;
  end

  assign ForwardAD = writeM && (WriteRegM == rsD);
  assign ForwardBD = writeM && (WriteRegM == rtD);

  assign lwStall = MemToRegE && writeE && ((WriteRegE == rsD) || (WriteRegE == rtD));
  assign brStall = BranchD &&
                   ((writeE && ((WriteRegE == rsD) || (WriteRegE == rtD))) ||
                    (loadM  && ((WriteRegM == rsD) || (WriteRegM == rtD))));
  assign mdStall = MdUseD && (mdState == BUSY);
  assign stall   = (lwStall || brStall || mdStall) && !RST;

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall || RST;
  // A stalled branch has not resolved yet, so it must not flush IF/ID.
  assign FlushD = ((PCSrcD || JumpD) && !stall) || RST;
  assign MdBusy = (mdState == BUSY) && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      mdState <= IDLE;
      mdCnt   <= '0;
    end else begin
      case (mdState)
        IDLE: begin
          if (MdStartE) begin
            mdState <= BUSY;
            mdCnt   <= CNT_W'(MD_LATENCY - 1);
          end
        end
        BUSY: begin
          mdCnt <= mdCnt - 1'b1;
          if (mdCnt == CNT_W'(1)) mdState <= IDLE;
        end
        default: mdState <= IDLE;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (stall && (StallCount != 32'hFFFF_FFFF))  StallCount <= StallCount + 32'd1;
      if (FlushD && (FlushCount != 32'hFFFF_FFFF)) FlushCount <= FlushCount + 32'd1;
    end
  end
`else
  assign StallCount = 32'd0;
  assign FlushCount = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with MD_LATENCY=4.
`timescale 1ns/1ps
module tb_hazard_controller;

  logic       CLK, RST;
  logic [4:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM;
  logic       BranchD, PCSrcD, JumpD, MdStartE, MdUseD;
  logic        StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, MdBusy;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] StallCount, FlushCount;

  int errors = 0;
  int checks = 0;

  hazard_controller #(.MD_LATENCY(4), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .MemToRegM(MemToRegM),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .JumpD(JumpD),
    .MdStartE(MdStartE), .MdUseD(MdUseD),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MdBusy(MdBusy), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearIn();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemToRegE = 0; MemToRegM = 0;
    BranchD = 0; PCSrcD = 0; JumpD = 0; MdStartE = 0; MdUseD = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chkCounts(input string tag, input int expStall, input int expFlush);
`ifdef HAZ_PERF_CNT_EN
    chk({tag, "_stallcnt"}, StallCount, 32'(expStall));
    chk({tag, "_flushcnt"}, FlushCount, 32'(expFlush));
`else
    chk({tag, "_stallcnt"}, StallCount, 32'd0);
    chk({tag, "_flushcnt"}, FlushCount, 32'd0);
`endif
  endtask

  initial begin
    clearIn();
    RST = 1'b1;
    // Load-use condition present during reset must not raise a stall.
    MemToRegE = 1; RegWriteE = 1; WriteRegE = 9; rtD = 9;
    tick();
    chk("rst_stallF", StallF, 1'b0);
    chk("rst_stallD", StallD, 1'b0);
    chk("rst_flushD", FlushD, 1'b1);
    chk("rst_flushE", FlushE, 1'b1);
    chk("rst_mdbusy", MdBusy, 1'b0);
    chkCounts("rst", 0, 0);

    clearIn();
    RST = 1'b0;
    #1;
    chk("idle_flushD", FlushD, 1'b0);
    chk("idle_flushE", FlushE, 1'b0);

    // Forwarding
    RegWriteM = 1; WriteRegM = 8; RegWriteW = 1; WriteRegW = 8; rsE = 8; rtE = 8;
    #1;
    chk("fwd_AE_mem_prio", ForwardAE, 2'b10);
    chk("fwd_BE_mem_prio", ForwardBE, 2'b10);
    RegWriteM = 0;
    #1;
    chk("fwd_AE_wb", ForwardAE, 2'b01);
    rsE = 0; WriteRegM = 0; WriteRegW = 0; RegWriteM = 1;
    #1;
    chk("fwd_AE_zero_reg", ForwardAE, 2'b00);
    WriteRegM = 6; WriteRegW = 5; rtE = 5;
    #1;
    chk("fwd_BE_wb_only", ForwardBE, 2'b01);
    WriteRegM = 3; rsD = 3; rtD = 0;
    #1;
    chk("fwd_AD", ForwardAD, 1'b1);
    chk("fwd_BD_nomatch", ForwardBD, 1'b0);

    // Load-use stalls x5, jump held during the first one
    for (int i = 0; i < 5; i++) begin
      clearIn();
      MemToRegE = 1; RegWriteE = 1; WriteRegE = 9; rtD = 9;
      if (i == 0) JumpD = 1;
      #1;
      if (i == 0) begin
        chk("lw_stallF", StallF, 1'b1);
        chk("lw_stallD", StallD, 1'b1);
        chk("lw_flushE", FlushE, 1'b1);
        chk("lw_jump_suppressed", FlushD, 1'b0);
      end
      tick();
      clearIn();
      MemToRegM = 1; RegWriteM = 1; WriteRegM = 9; rtE = 9; rtD = 9;
      #1;
      if (i == 0) begin
        chk("lw_release", StallF, 1'b0);
        chk("lw_fwd_BE", ForwardBE, 2'b10);
      end
      tick();
    end
    clearIn();
    MemToRegE = 1; RegWriteE = 1; WriteRegE = 0; rsD = 0;
    #1;
    chk("lw_r0_nostall", StallF, 1'b0);

    // Two taken jumps
    for (int i = 0; i < 2; i++) begin
      clearIn();
      JumpD = 1;
      #1;
      chk("jump_flushD", FlushD, 1'b1);
      tick();
      clearIn();
      tick();
    end
    chkCounts("after_lw_jump", 5, 2);

    // Branch dependent on EX producer, then producer in MEM
    clearIn();
    BranchD = 1; PCSrcD = 1; RegWriteE = 1; WriteRegE = 3; rsD = 3;
    #1;
    chk("br_stall", StallF, 1'b1);
    chk("br_flushD_held", FlushD, 1'b0);
    tick();
    RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 3;
    #1;
    chk("br_release", StallF, 1'b0);
    chk("br_fwd_AD", ForwardAD, 1'b1);
    chk("br_taken_flushD", FlushD, 1'b1);
    tick();
    clearIn();
    BranchD = 1; MemToRegM = 1; WriteRegM = 4; rtD = 4;
    #1;
    chk("br_load_mem_stall", StallD, 1'b1);
    tick();
    clearIn();
    BranchD = 1; RegWriteE = 1; WriteRegE = 0; rsD = 0;
    #1;
    chk("br_r0_nostall", StallF, 1'b0);
    clearIn();
    #1;
    chkCounts("after_branch", 7, 3);

    // Mult/div, MD_LATENCY=4
    MdStartE = 1; MdUseD = 1;
    #1;
    chk("md_c0_busy", MdBusy, 1'b0);
    chk("md_c0_stall", StallF, 1'b0);
    tick();
    MdStartE = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) MdStartE = 1;
      if (c == 3) begin
        MdStartE = 0;
        MemToRegE = 1; RegWriteE = 1; WriteRegE = 7; rsD = 7;
      end
      #1;
      chk($sformatf("md_c%0d_busy", c), MdBusy, 1'b1);
      chk($sformatf("md_c%0d_stall", c), StallF, 1'b1);
      tick();
    end
    clearIn();
    MdUseD = 1;
    #1;
    chk("md_c4_busy", MdBusy, 1'b0);
    chk("md_c4_stall", StallF, 1'b0);
    chkCounts("after_md", 10, 3);

    // Reset during BUSY
    clearIn();
    MdStartE = 1;
    tick();
    MdStartE = 0;
    tick();
    #1;
    chk("rb_busy_before", MdBusy, 1'b1);
    RST = 1; MdUseD = 1;
    #1;
    chk("rb_rst_stall", StallF, 1'b0);
    chk("rb_rst_flushD", FlushD, 1'b1);
    chk("rb_rst_flushE", FlushE, 1'b1);
    tick();
    RST = 0;
    #1;
    chk("rb_busy_after", MdBusy, 1'b0);
    chk("rb_nostall_after", StallF, 1'b0);
    chkCounts("rb", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
